// File: rtl/datapath_controller.sv
// Multi-cycle control FSM for the 16-bit register-file/ALU datapath.
// Accepts one instruction per handshake, sequences the datapath strobes, then pulses done.
module datapath_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] instr,
  output logic        in_ready,
  output logic        done,
  output logic        error,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] datapath_in
);

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 3;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG, S_WRITE_IMM, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] instr_q, instr_d;

  logic [2:0]    opcode;
  logic [1:0]    op;
  logic [RW-1:0] rn, rd, rm;
  logic [1:0]    sh;
  logic [7:0]    imm8;
  logic          is_mov_imm, is_mov_reg, is_alu, is_cmp, needs_a, illegal;

  assign opcode = instr_q[15:13];
  assign op     = instr_q[12:11];
  assign rn     = instr_q[10:8];
  assign rd     = instr_q[7:5];
  assign sh     = instr_q[4:3];
  assign rm     = instr_q[2:0];
  assign imm8   = instr_q[7:0];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_cmp     = is_alu && (op == 2'b01);
  // MVN has no A operand; ADD, CMP and AND read Rn first.
  assign needs_a    = is_alu && (op != 2'b11);
  assign illegal    = !(is_mov_imm || is_mov_reg || is_alu);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  // Next state plus Moore decode of state and latched instruction.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    in_ready    = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    readnum     = '0;
    writenum    = '0;
    write       = 1'b0;
    vsel        = 1'b0;
    loada       = 1'b0;
    loadb       = 1'b0;
    loadc       = 1'b0;
    loads       = 1'b0;
    asel        = 1'b0;
    bsel        = 1'b0;
    shift       = '0;
    ALUop       = '0;
    datapath_in = '0;
    case (state_q)
      S_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          instr_d = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (illegal)         state_d = S_DONE;
        else if (is_mov_imm) state_d = S_WRITE_IMM;
        else if (needs_a)    state_d = S_GET_A;
        else                 state_d = S_GET_B;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = S_GET_B;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        state_d = S_ALU;
      end
      S_ALU: begin
        shift = sh;
        // MOV reg forces A to zero and adds, passing shifted B through.
        asel  = is_mov_reg;
        ALUop = is_mov_reg ? 2'b00 : op;
        if (is_cmp) begin
          loads   = 1'b1;
          state_d = S_DONE;
        end else begin
          loadc   = 1'b1;
          state_d = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        writenum = rd;
        write    = 1'b1;
        state_d  = S_DONE;
      end
      S_WRITE_IMM: begin
        writenum    = rn;
        vsel        = 1'b1;
        write       = 1'b1;
        datapath_in = {{8{imm8[7]}}, imm8};
        state_d     = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        error   = illegal;
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_datapath_controller.sv
// Directed-vector bench for datapath_controller: per-cycle output words checked
// against hand-computed values, including mid-instruction reset.
module tb_datapath_controller;

  logic        clk, reset, in_valid;
  logic [15:0] instr;
  logic        in_ready, done, error;
  logic [2:0]  readnum, writenum;
  logic        write, vsel, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  shift, ALUop;
  logic [15:0] datapath_in;

  int n_vec = 0;
  int n_err = 0;

  datapath_controller dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr),
    .in_ready(in_ready), .done(done), .error(error),
    .readnum(readnum), .writenum(writenum),
    .write(write), .vsel(vsel), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
    .shift(shift), .ALUop(ALUop), .datapath_in(datapath_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe byte order: {write, vsel, loada, loadb, loadc, loads, asel, bsel}
  localparam logic [7:0] SW = 8'h80, SV = 8'h40, SA = 8'h20, SB = 8'h10,
                         SC = 8'h08, SS = 8'h04, SAS = 8'h02;

  function automatic logic [39:0] mk(input logic rdy, input logic dn, input logic er,
                                     input logic [2:0] rn, input logic [2:0] wn,
                                     input logic [7:0] st, input logic [1:0] sh,
                                     input logic [1:0] aop, input logic [15:0] din);
    return {3'b000, rdy, dn, er, rn, wn, st, sh, aop, din};
  endfunction

  function automatic logic [39:0] obs();
    return {3'b000, in_ready, done, error, readnum, writenum,
            {write, vsel, loada, loadb, loadc, loads, asel, bsel},
            shift, ALUop, datapath_in};
  endfunction

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [39:0] exp_q[$];
  logic [39:0] idle_w, zero_w;

  // Offer ins at the next edge, then check exp_q at cycles 1..N (sampled on negedge).
  task automatic apply(input string name, input logic [15:0] ins);
    in_valid = 1'b1;
    instr    = ins;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    instr    = 16'h0000;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s c%0d", name, i + 1), obs(), exp_q[i]);
      if (i < exp_q.size() - 1) @(negedge clk);
    end
    exp_q.delete();
  endtask

  initial begin
    idle_w   = mk(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 2'd0, 2'd0, 16'h0000);
    zero_w   = mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 2'd0, 2'd0, 16'h0000);
    reset    = 1'b1;
    in_valid = 1'b1;
    instr    = 16'hD0FD;
    @(posedge clk);
    @(negedge clk);
    chk("reset_hold", obs(), idle_w);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle", obs(), idle_w);

    // MOV R0,#-3
    exp_q = '{zero_w,
              mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, SW | SV, 2'd0, 2'd0, 16'hFFFD),
              mk(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 8'h00, 2'd0, 2'd0, 16'h0000),
              idle_w};
    apply("movimm", 16'hD0FD);

    // MOV R7,#0x7F (positive immediate, no sign extension)
    exp_q = '{zero_w,
              mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd7, SW | SV, 2'd0, 2'd0, 16'h007F),
              mk(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 8'h00, 2'd0, 2'd0, 16'h0000),
              idle_w};
    apply("movimm7", 16'hD77F);

    // ADD R2,R1,R0,LSL
    exp_q = '{zero_w,
              mk(1'b0, 1'b0, 1'b0, 3'd1, 3'd0, SA, 2'd0, 2'd0, 16'h0000),
              mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, SB, 2'd0, 2'd0, 16'h0000),
              mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, SC, 2'd1, 2'd0, 16'h0000),
              mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd2, SW, 2'd0, 2'd0, 16'h0000),
              mk(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 8'h00, 2'd0, 2'd0, 16'h0000),
              idle_w};
    apply("add", 16'hA148);

    // CMP R3,R4
    exp_q = '{zero_w,
              mk(1'b0, 1'b0, 1'b0, 3'd3, 3'd0, SA, 2'd0, 2'd0, 16'h0000),
              mk(1'b0, 1'b0, 1'b0, 3'd4, 3'd0, SB, 2'd0, 2'd0, 16'h0000),
              mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, SS, 2'd0, 2'd1, 16'h0000),
              mk(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 8'h00, 2'd0, 2'd0, 16'h0000),
              idle_w};
    apply("cmp", 16'hAB04);

    // MOV R5,R6
    exp_q = '{zero_w,
              mk(1'b0, 1'b0, 1'b0, 3'd6, 3'd0, SB, 2'd0, 2'd0, 16'h0000),
              mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, SC | SAS, 2'd0, 2'd0, 16'h0000),
              mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd5, SW, 2'd0, 2'd0, 16'h0000),
              mk(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 8'h00, 2'd0, 2'd0, 16'h0000),
              idle_w};
    apply("movreg", 16'hC0A6);

    // MVN R1,R2,LSR
    exp_q = '{zero_w,
              mk(1'b0, 1'b0, 1'b0, 3'd2, 3'd0, SB, 2'd0, 2'd0, 16'h0000),
              mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, SC, 2'd2, 2'd3, 16'h0000),
              mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd1, SW, 2'd0, 2'd0, 16'h0000),
              mk(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 8'h00, 2'd0, 2'd0, 16'h0000),
              idle_w};
    apply("mvn", 16'hB832);

    // AND R4,R7,R3,ASR
    exp_q = '{zero_w,
              mk(1'b0, 1'b0, 1'b0, 3'd7, 3'd0, SA, 2'd0, 2'd0, 16'h0000),
              mk(1'b0, 1'b0, 1'b0, 3'd3, 3'd0, SB, 2'd0, 2'd0, 16'h0000),
              mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, SC, 2'd3, 2'd2, 16'h0000),
              mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd4, SW, 2'd0, 2'd0, 16'h0000),
              mk(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 8'h00, 2'd0, 2'd0, 16'h0000),
              idle_w};
    apply("and", 16'hB79B);

    // Illegal opcode 000
    exp_q = '{zero_w,
              mk(1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 8'h00, 2'd0, 2'd0, 16'h0000),
              idle_w};
    apply("ill0000", 16'h0000);

    // Illegal 110/11 and 110/01 (MOV family gaps)
    exp_q = '{zero_w,
              mk(1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 8'h00, 2'd0, 2'd0, 16'h0000),
              idle_w};
    apply("ill110_11", 16'hD8FF);
    exp_q = '{zero_w,
              mk(1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 8'h00, 2'd0, 2'd0, 16'h0000),
              idle_w};
    apply("ill110_01", 16'hC8A6);

    // Reset pulsed in GET_B of an ADD while 0xD0FD stays offered
    in_valid = 1'b1;
    instr    = 16'hA148;
    @(posedge clk);
    @(negedge clk);
    instr = 16'hD0FD;
    chk("rst decode", obs(), zero_w);
    @(negedge clk);
    chk("rst get_a", obs(), mk(1'b0, 1'b0, 1'b0, 3'd1, 3'd0, SA, 2'd0, 2'd0, 16'h0000));
    @(negedge clk);
    chk("rst get_b", obs(), mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, SB, 2'd0, 2'd0, 16'h0000));
    #1 reset = 1'b1;
    #1 chk("rst async", obs(), idle_w);
    @(posedge clk);
    #1 chk("rst wins", obs(), idle_w);
    @(posedge clk);
    #1 chk("rst wins2", obs(), idle_w);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    instr    = 16'h0000;
    chk("post_rst c1", obs(), zero_w);
    @(negedge clk);
    chk("post_rst c2", obs(), mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, SW | SV, 2'd0, 2'd0, 16'hFFFD));
    @(negedge clk);
    chk("post_rst c3", obs(), mk(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 8'h00, 2'd0, 2'd0, 16'h0000));
    @(negedge clk);
    chk("post_rst c4", obs(), idle_w);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
